// File: rtl/valu_fp32_result_collector.sv
// Collects per-lane FP32 adder results into a wave-wide VGPR writeback.
// NaN and overflow results are canonicalised, and wave exception status is sticky.
module valu_fp32_result_collector #(
    parameter int LANES   = 32,
    parameter int DATA_W  = 32,
    parameter int VADDR_W = 8,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic [DATA_W-1:0]         res_data,
    input  logic                      res_nan,
    input  logic                      res_ovf,
    input  logic [LANE_W-1:0]         res_lane,
    input  logic [VADDR_W-1:0]        res_vdst,
    input  logic                      res_last,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [VADDR_W-1:0]        wb_vdst,
    output logic [LANES*DATA_W-1:0]   wb_data,
    output logic [LANES-1:0]          wb_mask,
    output logic                      exc_nan,
    output logic                      exc_ovf,
    output logic                      exc_err,
    input  logic                      exc_clr
);

    localparam logic [DATA_W-1:0] CANON_QNAN = DATA_W'(32'h7FC0_0000);

    typedef enum logic {COLLECT, WRITE} state_t;

    state_t              state, state_nx;
    logic                batch_open;
    logic                accept;
    logic                vdst_ok;
    logic                lane_we;
    logic [DATA_W-1:0]   lane_val;

    // Handshake outputs decode the state directly, so reset drops wb_valid at once.
    assign res_ready = (state == COLLECT);
    assign wb_valid  = (state == WRITE);
    assign accept    = res_valid & res_ready;
    assign vdst_ok   = !batch_open || (res_vdst == wb_vdst);
    assign lane_we   = accept & vdst_ok;

    // NaN wins over overflow; the adder's NaN payload and sign are not trusted.
    always_comb begin
        lane_val = res_data;
        if (res_nan)
            lane_val = CANON_QNAN;
        else if (res_ovf)
            lane_val = {res_data[DATA_W-1], 8'hFF, {(DATA_W-9){1'b0}}};
    end

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: if (accept && res_last) state_nx = WRITE;
            WRITE:   if (wb_ready)           state_nx = COLLECT;
            default:                         state_nx = COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= COLLECT;
        else
            state <= state_nx;
    end

    // NOTE: wb_data is a register bank, not a RAM, so it can and does take the reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data    <= '0;
            wb_mask    <= '0;
            wb_vdst    <= '0;
            batch_open <= 1'b0;
        end else if (wb_valid && wb_ready) begin
            // Data is left in place; the cleared mask marks it stale.
            wb_mask    <= '0;
            batch_open <= 1'b0;
        end else if (accept) begin
            if (!batch_open) begin
                wb_vdst    <= res_vdst;
                batch_open <= 1'b1;
            end
            for (int i = 0; i < LANES; i++) begin
                if (lane_we && (res_lane == LANE_W'(i))) begin
                    wb_data[i*DATA_W +: DATA_W] <= lane_val;
                    wb_mask[i]                  <= 1'b1;
                end
            end
        end
    end

    // A set and a clear on the same edge leave the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_nan <= 1'b0;
            exc_ovf <= 1'b0;
            exc_err <= 1'b0;
        end else begin
            exc_nan <= (exc_nan & ~exc_clr) | (accept & res_nan);
            exc_ovf <= (exc_ovf & ~exc_clr) | (accept & ~res_nan & res_ovf);
            exc_err <= (exc_err & ~exc_clr) | (accept & ~vdst_ok);
        end
    end

endmodule

// File: tb/tb_valu_fp32_result_collector.sv
// Directed bench for valu_fp32_result_collector.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_valu_fp32_result_collector;

    localparam int LANES   = 32;
    localparam int DATA_W  = 32;
    localparam int VADDR_W = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     res_valid;
    logic                     res_ready;
    logic [DATA_W-1:0]        res_data;
    logic                     res_nan;
    logic                     res_ovf;
    logic [4:0]               res_lane;
    logic [VADDR_W-1:0]       res_vdst;
    logic                     res_last;
    logic                     wb_valid;
    logic                     wb_ready;
    logic [VADDR_W-1:0]       wb_vdst;
    logic [LANES*DATA_W-1:0]  wb_data;
    logic [LANES-1:0]         wb_mask;
    logic                     exc_nan;
    logic                     exc_ovf;
    logic                     exc_err;
    logic                     exc_clr;

    int errors = 0;
    int checks = 0;

    valu_fp32_result_collector #(.LANES(LANES), .DATA_W(DATA_W), .VADDR_W(VADDR_W)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_nan(res_nan), .res_ovf(res_ovf), .res_lane(res_lane),
        .res_vdst(res_vdst), .res_last(res_last),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_vdst(wb_vdst),
        .wb_data(wb_data), .wb_mask(wb_mask),
        .exc_nan(exc_nan), .exc_ovf(exc_ovf), .exc_err(exc_err), .exc_clr(exc_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] lane_of(input int i);
        return wb_data[i*DATA_W +: DATA_W];
    endfunction

    // One accepted beat: drive at a falling edge, return at the next falling edge.
    task automatic send(input int lane, input logic [31:0] data, input logic nan,
                        input logic ovf, input logic [7:0] vdst, input logic last);
        res_valid = 1'b1;
        res_lane  = 5'(lane);
        res_data  = data;
        res_nan   = nan;
        res_ovf   = ovf;
        res_vdst  = vdst;
        res_last  = last;
        @(negedge clk);
        res_valid = 1'b0;
        res_last  = 1'b0;
        res_nan   = 1'b0;
        res_ovf   = 1'b0;
    endtask

    task automatic pulse_clr();
        exc_clr = 1'b1;
        @(negedge clk);
        exc_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; res_valid = 1'b0; res_data = '0; res_nan = 1'b0; res_ovf = 1'b0;
        res_lane = '0; res_vdst = '0; res_last = 1'b0; wb_ready = 1'b1; exc_clr = 1'b0;
        @(negedge clk);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_res_ready", 64'(res_ready), 64'd1);
        check("rst_wb_mask", 64'(wb_mask), 64'd0);
        check("rst_wb_vdst", 64'(wb_vdst), 64'd0);
        check("rst_lane0", 64'(lane_of(0)), 64'd0);
        check("rst_exc", 64'({exc_nan, exc_ovf, exc_err}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full 32-lane batch, immediate writeback acceptance.
        for (int i = 0; i < 32; i++)
            send(i, 32'h3F80_0000 + 32'(i), 1'b0, 1'b0, 8'h05, i == 31);
        check("full_wb_valid", 64'(wb_valid), 64'd1);
        check("full_res_ready_low", 64'(res_ready), 64'd0);
        check("full_mask", 64'(wb_mask), 64'hFFFF_FFFF);
        check("full_vdst", 64'(wb_vdst), 64'h05);
        for (int i = 0; i < 32; i += 5)
            check($sformatf("full_lane%0d", i), 64'(lane_of(i)), 64'(32'h3F80_0000 + 32'(i)));
        check("full_lane31", 64'(lane_of(31)), 64'h3F80_001F);
        @(negedge clk);
        check("full_done_valid", 64'(wb_valid), 64'd0);
        check("full_done_ready", 64'(res_ready), 64'd1);
        check("full_done_mask", 64'(wb_mask), 64'd0);

        // NaN and overflow canonicalisation, then sticky clear.
        send(3, 32'hDEAD_BEEF, 1'b1, 1'b1, 8'h05, 1'b0);
        send(4, 32'h8000_0000, 1'b0, 1'b1, 8'h05, 1'b1);
        check("exc_lane3_nan", 64'(lane_of(3)), 64'h7FC0_0000);
        check("exc_lane4_ovf", 64'(lane_of(4)), 64'hFF80_0000);
        check("exc_mask", 64'(wb_mask), 64'h18);
        check("exc_nan_set", 64'(exc_nan), 64'd1);
        check("exc_ovf_set", 64'(exc_ovf), 64'd1);
        check("exc_err_clear", 64'(exc_err), 64'd0);
        @(negedge clk);
        pulse_clr();
        check("exc_cleared", 64'({exc_nan, exc_ovf, exc_err}), 64'd0);

        // Destination mismatch drops the lane and raises exc_err.
        send(0, 32'h1111_1111, 1'b0, 1'b0, 8'h05, 1'b0);
        send(1, 32'h2222_2222, 1'b0, 1'b0, 8'h06, 1'b0);
        send(2, 32'h3333_3333, 1'b0, 1'b0, 8'h05, 1'b1);
        check("mm_wb_valid", 64'(wb_valid), 64'd1);
        check("mm_mask", 64'(wb_mask), 64'h5);
        check("mm_vdst", 64'(wb_vdst), 64'h05);
        check("mm_err", 64'(exc_err), 64'd1);
        check("mm_lane1_kept", 64'(lane_of(1)), 64'h3F80_0001);
        check("mm_lane2", 64'(lane_of(2)), 64'h3333_3333);
        @(negedge clk);
        pulse_clr();

        // Back-pressure: writeback held for five cycles, upstream beats ignored.
        wb_ready = 1'b0;
        send(9, 32'h1234_5678, 1'b0, 1'b0, 8'h20, 1'b1);
        res_valid = 1'b1; res_lane = 5'd10; res_data = 32'hBAD0_BAD0;
        res_vdst = 8'h20; res_last = 1'b1; res_nan = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_valid_c%0d", k), 64'(wb_valid), 64'd1);
            check($sformatf("bp_ready_c%0d", k), 64'(res_ready), 64'd0);
            check($sformatf("bp_mask_c%0d", k), 64'(wb_mask), 64'h200);
            check($sformatf("bp_vdst_c%0d", k), 64'(wb_vdst), 64'h20);
            check($sformatf("bp_lane9_c%0d", k), 64'(lane_of(9)), 64'h1234_5678);
            @(negedge clk);
        end
        check("bp_lane10_untouched", 64'(lane_of(10)), 64'h3F80_000A);
        check("bp_nan_ignored", 64'(exc_nan), 64'd0);
        res_valid = 1'b0; res_last = 1'b0; res_nan = 1'b0;
        wb_ready = 1'b1;
        @(negedge clk);
        check("bp_done_valid", 64'(wb_valid), 64'd0);
        check("bp_done_ready", 64'(res_ready), 64'd1);
        check("bp_done_mask", 64'(wb_mask), 64'd0);

        // Duplicate lane: later value wins.
        send(7, 32'h4000_0000, 1'b0, 1'b0, 8'h01, 1'b0);
        send(7, 32'h4040_0000, 1'b0, 1'b0, 8'h01, 1'b1);
        check("dup_lane7", 64'(lane_of(7)), 64'h4040_0000);
        check("dup_mask", 64'(wb_mask), 64'h80);
        check("dup_vdst", 64'(wb_vdst), 64'h01);
        @(negedge clk);

        // Reset part-way through a batch carrying sticky flags.
        for (int i = 0; i < 10; i++)
            send(i, 32'h4100_0000 + 32'(i), i == 2, 1'b0, (i == 9) ? 8'h04 : 8'h03, 1'b0);
        check("pre_rst_flags", 64'({exc_nan, exc_err}), 64'b11);
        check("pre_rst_mask", 64'(wb_mask), 64'h1FF);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(wb_valid), 64'd0);
        check("mid_rst_exc", 64'({exc_nan, exc_ovf, exc_err}), 64'd0);
        check("mid_rst_mask", 64'(wb_mask), 64'd0);
        check("mid_rst_lane0", 64'(lane_of(0)), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset while a writeback is pending drops wb_valid without a clock edge.
        wb_ready = 1'b0;
        send(5, 32'h5555_5555, 1'b0, 1'b0, 8'h09, 1'b1);
        check("wr_pending_valid", 64'(wb_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("wr_rst_valid_async", 64'(wb_valid), 64'd0);
        check("wr_rst_ready", 64'(res_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        wb_ready = 1'b1;
        @(negedge clk);

        // Single-beat batch after reset.
        send(0, 32'h3F80_0000, 1'b0, 1'b0, 8'h02, 1'b1);
        check("one_valid", 64'(wb_valid), 64'd1);
        check("one_mask", 64'(wb_mask), 64'h1);
        check("one_vdst", 64'(wb_vdst), 64'h02);
        check("one_lane0", 64'(lane_of(0)), 64'h3F80_0000);
        @(negedge clk);
        check("one_done_valid", 64'(wb_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
